i2c_burst_sequencer: RTL and testbench
======================================

# i2c_burst_sequencer

Multi-byte I2C transaction sequencer for the Nexys 4 DDR sensor path. It sits between user logic and the single-byte `i2c_controller`. It expands one user request (read or write of 1..`MAX_BYTES` consecutive registers) into a series of controller operations, including the register-pointer write and repeated-start hold for each read byte. It returns packed read data with a single `done` pulse.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `MAX_BYTES`, 4: maximum bytes per request, ≥1.
- `REPEAT_HOLD_NS`, 10000: gap between pointer write and repeated-start read.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request strobe; sampled only in IDLE.
- `rd_wr` in 1: 0 = write, 1 = read.
- `bus_address` in 7: slave address.
- `reg_address` in 8: first register.
- `byte_count` in CW=$clog2(MAX_BYTES+1): bytes requested.
- `wr_data` in 8*MAX_BYTES: byte i in [8i+7:8i].
- `rd_data` out 8*MAX_BYTES: byte i in [8i+7:8i].
- `busy`, `done`, `error` out 1 each: status.
- `ctl_start`, `ctl_repeat_start`, `ctl_continu`, `ctl_rd_wr` out 1 each: controller controls.
- `ctl_bus_address` out 7: to controller.
- `ctl_address`, `ctl_data_to_send` out 8 each: to controller.
- `ctl_data_received` in 8: from controller.
- `ctl_busy`, `ctl_done`, `ctl_error` in 1 each: controller status. `ctl_error` is valid with `ctl_done`.

## Operation
- Request acceptance: when `start`=1 in IDLE, latch `rd_wr`, `bus_address`, `reg_address`, `wr_data` and the effective count N.
  - N = 1 if `byte_count`=0.
  - N = MAX_BYTES if `byte_count`>MAX_BYTES.
  - Otherwise N = `byte_count`.
  - Clear `rd_data` and `error`. Set byte index i=0.
- States: IDLE, WR_ISSUE, WR_WAIT, PTR_ISSUE, PTR_WAIT, HOLD, RD_ISSUE, RD_WAIT, NEXT, FINISH.
- Write byte i:
  - WR_ISSUE pulses `ctl_start` with `ctl_rd_wr`=0, `ctl_address`=reg+i, `ctl_data_to_send`=byte i.
  - WR_WAIT waits for `ctl_done`.
- Read byte i:
  - PTR_ISSUE pulses `ctl_start` with `ctl_rd_wr`=0, `ctl_address`=reg+i. PTR_WAIT waits for `ctl_done`.
  - HOLD counts HOLD_CYCLES = REPEAT_HOLD_NS*CLK_FREQ/1e9, truncated, minimum 1.
  - RD_ISSUE pulses `ctl_start` with `ctl_rd_wr`=1, `ctl_repeat_start`=1, `ctl_continu`=1.
  - RD_WAIT waits for `ctl_done`, then stores `ctl_data_received` into rd_data byte i.
- Register address: reg+i wraps modulo 256 (0xFF+1 → 0x00).
- NEXT: if i=N-1, go to FINISH; else increment i and return to WR_ISSUE or PTR_ISSUE.
- Controller error: `ctl_done` with `ctl_error`=1 in any WAIT state aborts the request.
  - The remaining bytes are skipped; go to FINISH with `error`=1.
  - `rd_data` keeps the bytes captured so far.
- FINISH: `done`=1 for exactly one cycle, then IDLE.
- `start` in any state other than IDLE is ignored; it is not queued.
- `ctl_start` is never asserted while `ctl_busy`=1; ISSUE states stall until `ctl_busy`=0.

## Timing
- Reset values:
  - `busy`, `done`, `error`, all `ctl_*` outputs: 0.
  - `rd_data`: 0. State: IDLE. Hold counter: 0.
- `busy` rises the cycle after `start` is accepted and falls in the same cycle `done` pulses.
- `ctl_start` is a registered one-cycle pulse, asserted on the first ISSUE cycle with `ctl_busy`=0.
  - `ctl_address`, `ctl_data_to_send` and `ctl_rd_wr` are stable from that pulse until `ctl_done`.
- `ctl_repeat_start` and `ctl_continu` are asserted from RD_ISSUE through RD_WAIT, and are 0 otherwise.
- HOLD lasts exactly HOLD_CYCLES cycles. At 100 MHz that is 1000 cycles.
- `rd_data` byte i updates the cycle after `ctl_done` in RD_WAIT.
- `error` holds its value until the next accepted `start`.
- `rst` mid-request: all outputs return to reset values asynchronously. No `done` is generated.

## Configuration
- `I2C_SEQ_RETRY_EN`:
  - Defined: on controller error, wait HOLD_CYCLES, then restart the whole request from i=0. Up to RETRY_LIMIT (3) restarts are allowed. `error`=1 only if the final attempt fails. `rd_data` is cleared on each restart.
  - Undefined: abort on the first error, as described in Operation. The retry counter logic is absent.

## Structure
- Package `i2c_seq_pkg`: state enum `seq_state_t`, `RETRY_LIMIT`, and function `hold_cycles(clk_freq, ns)`.
- Sub-module `i2c_hold_timer`:
  - Loadable down-counter with `load` and `expired` outputs.
  - Used for HOLD and for the retry back-off.
- The top-level integration instantiates `i2c_burst_sequencer` and `i2c_controller` side by side.

## Test plan
- Write N=3, reg 0x10, `wr_data`=0x00CC_BBAA → three `ctl_start` pulses at addresses 0x10/0x11/0x12 with data AA/BB/CC → one `done`, `error`=0.
- Read N=2, reg 0x00; controller model returns 0x0B, 0xAC → each byte shows a pointer write, 1000-cycle hold, then repeated-start read → `rd_data`[15:0]=0xAC0B.
- Read N=2 at reg 0xFF → second byte addresses 0x00.
- `byte_count`=0 → one byte transferred. `byte_count`=7 → 4 bytes transferred.
- `ctl_error` on byte 1 of 3, macro undefined → `done` with `error`=1, byte 2 never issued. Macro defined with two failures → request restarts twice and completes with `error`=0.
- `rst` asserted during HOLD → `busy` and `ctl_*` go to 0 immediately, no `done`. A new `start` after reset works normally.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C burst sequencer.
// Holds the FSM state encoding, the retry budget and the repeated-start hold computation.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    PTR_ISSUE,
    PTR_WAIT,
    HOLD,
    RD_ISSUE,
    RD_WAIT,
    NEXT,
    FINISH
  } seq_state_t;

  localparam int RETRY_LIMIT = 3;

  // Hold length in clock cycles: truncated ns-to-cycles conversion, never below one cycle.
  function automatic int hold_cycles(input longint clk_freq, input longint ns);
    longint c;
    c = (clk_freq * ns) / 64'd1_000_000_000;
    if (c < 1) c = 1;
    return int'(c);
  endfunction

endpackage

// File: rtl/i2c_burst_sequencer_if.sv
// User request and controller-side signals of the I2C burst sequencer.
// slave: the sequencer's view; master: the view of the logic surrounding it.
interface i2c_burst_sequencer_if #(
  parameter int MAX_BYTES = 4
);
  localparam int CW = $clog2(MAX_BYTES + 1);

  logic                   start;
  logic                   rd_wr;
  logic [6:0]             bus_address;
  logic [7:0]             reg_address;
  logic [CW-1:0]          byte_count;
  logic [8*MAX_BYTES-1:0] wr_data;
  logic [8*MAX_BYTES-1:0] rd_data;
  logic                   busy;
  logic                   done;
  logic                   error;

  logic                   ctl_start;
  logic                   ctl_repeat_start;
  logic                   ctl_continu;
  logic                   ctl_rd_wr;
  logic [6:0]             ctl_bus_address;
  logic [7:0]             ctl_address;
  logic [7:0]             ctl_data_to_send;
  logic [7:0]             ctl_data_received;
  logic                   ctl_busy;
  logic                   ctl_done;
  logic                   ctl_error;

  modport slave (
    input  start, rd_wr, bus_address, reg_address, byte_count, wr_data,
    output rd_data, busy, done, error,
    output ctl_start, ctl_repeat_start, ctl_continu, ctl_rd_wr,
    output ctl_bus_address, ctl_address, ctl_data_to_send,
    input  ctl_data_received, ctl_busy, ctl_done, ctl_error
  );

  modport master (
    output start, rd_wr, bus_address, reg_address, byte_count, wr_data,
    input  rd_data, busy, done, error,
    input  ctl_start, ctl_repeat_start, ctl_continu, ctl_rd_wr,
    input  ctl_bus_address, ctl_address, ctl_data_to_send,
    output ctl_data_received, ctl_busy, ctl_done, ctl_error
  );

endinterface

// File: rtl/i2c_hold_timer.sv
// Loadable down-counter used for the repeated-start hold and the retry back-off.
// expired is high whenever the count has reached zero.
module i2c_hold_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/i2c_burst_sequencer.sv
// Expands one multi-byte register read/write request into single-byte i2c_controller operations.
// Optional `I2C_SEQ_RETRY_EN: restart the whole request after a controller error, up to RETRY_LIMIT times.
module i2c_burst_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int MAX_BYTES      = 4,
  parameter int REPEAT_HOLD_NS = 10000
) (
  input logic                  clk,
  input logic                  rst,
  i2c_burst_sequencer_if.slave bus
);

  localparam int CW          = $clog2(MAX_BYTES + 1);
  localparam int DW          = 8 * MAX_BYTES;
  localparam int HOLD_CYCLES = hold_cycles(longint'(CLK_FREQ), longint'(REPEAT_HOLD_NS));
  localparam int TW          = $clog2(HOLD_CYCLES + 1);

  seq_state_t    state, state_d;
  logic [CW-1:0] idx, idx_d;
  logic [CW-1:0] n_last, n_last_d;
  logic          rw_q, rw_d;
  logic [7:0]    reg_q, reg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          cs_q, cs_d;
  logic          rpt_q, rpt_d;
  logic          crw_q, crw_d;
  logic [6:0]    cbus_q, cbus_d;
  logic [7:0]    caddr_q, caddr_d;
  logic [7:0]    cdata_q, cdata_d;
  logic          timer_load;
  logic          timer_expired;
  int            sel;
`ifdef I2C_SEQ_RETRY_EN
  logic [1:0]    retry_q, retry_d;
  logic          retrying_q, retrying_d;
`endif

  i2c_hold_timer #(.W(TW)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (TW'(HOLD_CYCLES - 1)),
    .expired  (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      n_last  <= '0;
      rw_q    <= 1'b0;
      reg_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cs_q    <= 1'b0;
      rpt_q   <= 1'b0;
      crw_q   <= 1'b0;
      cbus_q  <= '0;
      caddr_q <= '0;
      cdata_q <= '0;
`ifdef I2C_SEQ_RETRY_EN
      retry_q    <= '0;
      retrying_q <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      n_last  <= n_last_d;
      rw_q    <= rw_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      cs_q    <= cs_d;
      rpt_q   <= rpt_d;
      crw_q   <= crw_d;
      cbus_q  <= cbus_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
`ifdef I2C_SEQ_RETRY_EN
      retry_q    <= retry_d;
      retrying_q <= retrying_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    n_last_d   = n_last;
    rw_d       = rw_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    error_d    = error_q;
    cs_d       = 1'b0;
    crw_d      = crw_q;
    cbus_d     = cbus_q;
    caddr_d    = caddr_q;
    cdata_d    = cdata_q;
    timer_load = 1'b0;
    sel        = 8 * int'(idx);
`ifdef I2C_SEQ_RETRY_EN
    retry_d    = retry_q;
    retrying_d = retrying_q;
`endif

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          rw_d    = bus.rd_wr;
          reg_d   = bus.reg_address;
          wdata_d = bus.wr_data;
          cbus_d  = bus.bus_address;
          rd_d    = '0;
          error_d = 1'b0;
          idx_d   = '0;
          // A zero count still moves one byte; oversize counts clamp to the buffer size.
          if (bus.byte_count == '0)                   n_last_d = '0;
          else if (bus.byte_count > CW'(MAX_BYTES))   n_last_d = CW'(MAX_BYTES - 1);
          else                                        n_last_d = bus.byte_count - CW'(1);
`ifdef I2C_SEQ_RETRY_EN
          retry_d    = '0;
          retrying_d = 1'b0;
`endif
          state_d = bus.rd_wr ? PTR_ISSUE : WR_ISSUE;
        end
      end

      WR_ISSUE, PTR_ISSUE, RD_ISSUE: begin
        if (!bus.ctl_busy) begin
          cs_d    = 1'b1;
          caddr_d = reg_q + 8'(idx);
          crw_d   = (state == RD_ISSUE);
          if (state == WR_ISSUE) cdata_d = wdata_q[sel +: 8];
          state_d = (state == WR_ISSUE)  ? WR_WAIT :
                    (state == PTR_ISSUE) ? PTR_WAIT : RD_WAIT;
        end
      end

      WR_WAIT, PTR_WAIT, RD_WAIT: begin
        if (bus.ctl_done) begin
          if (bus.ctl_error) begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_q != 2'(RETRY_LIMIT)) begin
              retry_d    = retry_q + 2'd1;
              retrying_d = 1'b1;
              timer_load = 1'b1;
              state_d    = HOLD;
            end else begin
              error_d = 1'b1;
              state_d = FINISH;
            end
`else
            error_d = 1'b1;
            state_d = FINISH;
`endif
          end else if (state == PTR_WAIT) begin
            timer_load = 1'b1;
            state_d    = HOLD;
          end else begin
            if (state == RD_WAIT) rd_d[sel +: 8] = bus.ctl_data_received;
            state_d = NEXT;
          end
        end
      end

      HOLD: begin
        if (timer_expired) begin
`ifdef I2C_SEQ_RETRY_EN
          if (retrying_q) begin
            retrying_d = 1'b0;
            idx_d      = '0;
            rd_d       = '0;
            state_d    = rw_q ? PTR_ISSUE : WR_ISSUE;
          end else begin
            state_d = RD_ISSUE;
          end
`else
          state_d = RD_ISSUE;
`endif
        end
      end

      NEXT: begin
        if (idx == n_last) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx + CW'(1);
          state_d = rw_q ? PTR_ISSUE : WR_ISSUE;
        end
      end

      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status and repeated-start flags follow the next state so they line up with it cycle-for-cycle.
    busy_d = (state_d != IDLE) && (state_d != FINISH);
    done_d = (state_d == FINISH);
    rpt_d  = (state_d == RD_ISSUE) || (state_d == RD_WAIT);
  end

  assign bus.rd_data          = rd_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;
  assign bus.ctl_start        = cs_q;
  assign bus.ctl_repeat_start = rpt_q;
  assign bus.ctl_continu      = rpt_q;
  assign bus.ctl_rd_wr        = crw_q;
  assign bus.ctl_bus_address  = cbus_q;
  assign bus.ctl_address      = caddr_q;
  assign bus.ctl_data_to_send = cdata_q;

endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// Scoreboard bench for i2c_burst_sequencer: directed requests against a behavioural controller model.
module tb_i2c_burst_sequencer;
  import i2c_seq_pkg::*;

  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_burst_sequencer_if #(.MAX_BYTES(MB)) m ();

  i2c_burst_sequencer #(
    .CLK_FREQ       (100_000_000),
    .MAX_BYTES      (MB),
    .REPEAT_HOLD_NS (10000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (m.slave)
  );

  typedef struct packed {
    logic        is_done;
    logic        rw;
    logic        chk_addr;
    logic        chk_data;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rd_q[$];
  logic       err_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  int last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void push_wr(logic [7:0] a, logic [7:0] d);
    exp_t e = '0;
    e.chk_addr = 1'b1; e.chk_data = 1'b1; e.addr = a; e.data = d;
    sb.push_back(e);
  endfunction

  function automatic void push_ptr(logic [7:0] a);
    exp_t e = '0;
    e.chk_addr = 1'b1; e.addr = a;
    sb.push_back(e);
  endfunction

  function automatic void push_rd();
    exp_t e = '0;
    e.rw = 1'b1;
    sb.push_back(e);
  endfunction

  function automatic void push_done(logic err, logic [31:0] rd);
    exp_t e = '0;
    e.is_done = 1'b1; e.err = err; e.rd = rd;
    sb.push_back(e);
  endfunction

  // Controller model: busy for three cycles after each ctl_start, then a one-cycle ctl_done.
  initial begin : ctl_model
    logic rw;
    m.ctl_busy = 1'b0; m.ctl_done = 1'b0; m.ctl_error = 1'b0; m.ctl_data_received = 8'h00;
    forever begin
      @(negedge clk);
      m.ctl_done  = 1'b0;
      m.ctl_error = 1'b0;
      if (!rst && m.ctl_start) begin
        rw = m.ctl_rd_wr;
        m.ctl_busy = 1'b1;
        repeat (3) @(negedge clk);
        m.ctl_busy  = 1'b0;
        m.ctl_done  = 1'b1;
        m.ctl_error = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
        if (rw) m.ctl_data_received = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
        last_done_cyc = cyc;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m.ctl_start) begin
          if (sb.size() == 0) chk("ctl_start_unexpected", m.ctl_start, 0);
          else begin
            e = sb.pop_front();
            if (e.is_done) chk("ctl_start_before_done", m.ctl_start, 0);
            else begin
              chk("ctl_rd_wr", m.ctl_rd_wr, e.rw);
              chk("ctl_bus_address", m.ctl_bus_address, 7'h1D);
              if (e.chk_addr) chk("ctl_address", m.ctl_address, e.addr);
              if (e.chk_data) chk("ctl_data_to_send", m.ctl_data_to_send, e.data);
              chk("ctl_repeat_start", m.ctl_repeat_start, e.rw);
              chk("ctl_continu", m.ctl_continu, e.rw);
              // 1000 hold cycles plus the cycle sampling ctl_done and the issue cycle.
              if (e.rw) chk("hold_gap", cyc - last_done_cyc, 1002);
            end
          end
        end
        if (m.done) begin
          done_cnt++;
          if (sb.size() == 0) chk("done_unexpected", m.done, 0);
          else begin
            e = sb.pop_front();
            if (!e.is_done) chk("done_early", m.done, 0);
            else begin
              chk("error", m.error, e.err);
              chk("rd_data", m.rd_data, e.rd);
              chk("busy_at_done", m.busy, 0);
            end
          end
        end
      end
    end
  end

  task automatic go(input logic rw, input logic [7:0] ra, input logic [2:0] bc,
                    input logic [31:0] wd, input logic dup);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    m.rd_wr = rw; m.reg_address = ra; m.byte_count = bc; m.wr_data = wd;
    m.bus_address = 7'h1D; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    chk("busy_rise", m.busy, 1);
    if (dup) begin
      repeat (2) @(negedge clk);
      m.reg_address = 8'h99; m.start = 1'b1;
      @(negedge clk);
      m.start = 1'b0;
    end
    for (int k = 0; k < 5000 && done_cnt == d0; k++) @(negedge clk);
    chk("done_timeout", 32'(done_cnt != d0), 1);
    chk("sb_drained", sb.size(), 0);
    sb.delete(); rd_q.delete(); err_q.delete();
  endtask

  initial begin : stim
    int d0;
    m.start = 1'b0; m.rd_wr = 1'b0; m.bus_address = '0; m.reg_address = '0;
    m.byte_count = '0; m.wr_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", m.busy, 0);
    chk("rst_done", m.done, 0);
    chk("rst_error", m.error, 0);
    chk("rst_rd_data", m.rd_data, 0);
    chk("rst_ctl_start", m.ctl_start, 0);
    chk("rst_ctl_repeat", m.ctl_repeat_start, 0);
    chk("rst_ctl_continu", m.ctl_continu, 0);
    chk("rst_ctl_rd_wr", m.ctl_rd_wr, 0);
    chk("rst_ctl_address", m.ctl_address, 0);
    chk("rst_ctl_data", m.ctl_data_to_send, 0);
    rst = 1'b0;

    // Write three bytes; a second start while busy must be ignored.
    push_wr(8'h10, 8'hAA); push_wr(8'h11, 8'hBB); push_wr(8'h12, 8'hCC);
    push_done(1'b0, 32'h0);
    go(1'b0, 8'h10, 3'd3, 32'h00CC_BBAA, 1'b1);

    // Read two bytes from 0x00.
    push_ptr(8'h00); push_rd(); push_ptr(8'h01); push_rd();
    push_done(1'b0, 32'h0000_AC0B);
    rd_q.push_back(8'h0B); rd_q.push_back(8'hAC);
    go(1'b1, 8'h00, 3'd2, 32'h0, 1'b0);

    // Register address wraps from 0xFF to 0x00.
    push_ptr(8'hFF); push_rd(); push_ptr(8'h00); push_rd();
    push_done(1'b0, 32'h0000_A55A);
    rd_q.push_back(8'h5A); rd_q.push_back(8'hA5);
    go(1'b1, 8'hFF, 3'd2, 32'h0, 1'b0);

    // byte_count 0 moves one byte; byte_count 7 clamps to four.
    push_wr(8'h20, 8'h11); push_done(1'b0, 32'h0);
    go(1'b0, 8'h20, 3'd0, 32'h4433_2211, 1'b0);
    push_wr(8'h30, 8'h11); push_wr(8'h31, 8'h22); push_wr(8'h32, 8'h33); push_wr(8'h33, 8'h44);
    push_done(1'b0, 32'h0);
    go(1'b0, 8'h30, 3'd7, 32'h4433_2211, 1'b0);

`ifdef I2C_SEQ_RETRY_EN
    // Two failures: byte 1 of attempt 1, byte 0 of attempt 2; attempt 3 succeeds.
    push_wr(8'h70, 8'h11); push_wr(8'h71, 8'h22);
    push_wr(8'h70, 8'h11);
    push_wr(8'h70, 8'h11); push_wr(8'h71, 8'h22); push_wr(8'h72, 8'h33);
    push_done(1'b0, 32'h0);
    err_q.push_back(1'b0); err_q.push_back(1'b1); err_q.push_back(1'b1);
    go(1'b0, 8'h70, 3'd3, 32'h0033_2211, 1'b0);
`else
    // Error on byte 1 of 3 aborts; byte 2 is never issued.
    push_wr(8'h70, 8'h11); push_wr(8'h71, 8'h22);
    push_done(1'b1, 32'h0);
    err_q.push_back(1'b0); err_q.push_back(1'b1);
    go(1'b0, 8'h70, 3'd3, 32'h0033_2211, 1'b0);
    repeat (5) @(negedge clk);
    chk("error_held", m.error, 1);

    // Read aborted on the second pointer write keeps the first captured byte.
    push_ptr(8'h40); push_rd(); push_ptr(8'h41);
    push_done(1'b1, 32'h0000_0077);
    rd_q.push_back(8'h77);
    err_q.push_back(1'b0); err_q.push_back(1'b0); err_q.push_back(1'b1);
    go(1'b1, 8'h40, 3'd2, 32'h0, 1'b0);
`endif

    // Reset in the middle of HOLD.
    push_ptr(8'h50);
    rd_q.push_back(8'h33);
    d0 = done_cnt;
    @(negedge clk);
    m.rd_wr = 1'b1; m.reg_address = 8'h50; m.byte_count = 3'd1; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    repeat (200) @(negedge clk);
    chk("hold_busy_before_rst", m.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", m.busy, 0);
    chk("rst_mid_ctl_start", m.ctl_start, 0);
    chk("rst_mid_ctl_address", m.ctl_address, 0);
    chk("rst_mid_ctl_bus_address", m.ctl_bus_address, 0);
    chk("rst_mid_done", m.done, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); rd_q.delete(); err_q.delete();
    repeat (1200) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);

    // Normal operation after reset.
    push_wr(8'h60, 8'h5C); push_done(1'b0, 32'h0);
    go(1'b0, 8'h60, 3'd1, 32'h0000_005C, 1'b0);

    chk("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
